// File: rtl/spi_minion.sv
// SPI minion (mode 0): synchronizes the master's cs/sclk/mosi into clk, shifts
// fixed nbits-wide packets in on mosi and out on miso, and hands packets downstream.
module spi_minion #(
    parameter int nbits = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             recv_val,
    input  logic             recv_rdy,
    output logic [nbits-1:0] recv_msg,
    input  logic             send_val,
    output logic             send_rdy,
    input  logic [nbits-1:0] send_msg,
    output logic             overflow,
    output logic             frame_err,
    output logic [0:0]       dbg_state
);

    localparam int CW = $clog2(nbits + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(nbits);
    localparam logic [CW-1:0] CNT_LAST = CW'(nbits - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [nbits-1:0] rx_shift;
    logic [nbits-1:0] tx_shift;
    logic             done_q;

    logic cs_s1, cs_s2, cs_s3;
    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;

    logic sclk_pos, sclk_neg, cs_fall, cs_rise;
    logic done;
    logic recv_write;

    // Two synchronizer stages per input; the third cs/sclk stage is only for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_pos = sclk_s2 & ~sclk_s3;
    assign sclk_neg = ~sclk_s2 & sclk_s3;
    assign cs_fall  = ~cs_s2 & cs_s3;
    assign cs_rise  = cs_s2 & ~cs_s3;

    // The shift that brings the counter to nbits completes the packet; saturation
    // of the counter guarantees this fires at most once per frame.
    assign done = (state == ACTIVE) && !cs_rise && sclk_pos && (bit_cnt == CNT_LAST);

    // Handshake: recv_msg is transferred on any cycle with recv_val && recv_rdy;
    // recv_val stays high and recv_msg stable until that transfer happens. send_rdy
    // is a one-cycle grant at frame start, independent of send_val; send_msg is
    // taken on that cycle only if send_val is high.
    assign send_rdy   = (state == IDLE) && cs_fall;
    assign recv_write = done_q && (!recv_val || recv_rdy);

    assign miso      = (state == ACTIVE) ? tx_shift[nbits-1] : 1'b0;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            done_q    <= 1'b0;
            recv_msg  <= '0;
            recv_val  <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done_q    <= done;
            overflow  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= send_val ? send_msg : '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        if (bit_cnt != CNT_FULL) begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (sclk_pos && (bit_cnt != CNT_FULL)) begin
                            rx_shift <= {rx_shift[nbits-2:0], mosi_s2};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                        if (sclk_neg) begin
                            tx_shift <= {tx_shift[nbits-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (recv_write) begin
                recv_msg <= rx_shift;
                recv_val <= 1'b1;
            end else if (recv_val && recv_rdy) begin
                recv_val <= 1'b0;
            end

            if (done_q && recv_val && !recv_rdy) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_minion.sv
// Directed bench for spi_minion: a mode-0 SPI master task drives frames while a
// monitor pops expected packets from a queue on every recv handshake.
`timescale 1ns/1ps
module tb_spi_minion;

    localparam int NB = 34;

    logic          clk;
    logic          reset;
    logic          cs;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          recv_val;
    logic          recv_rdy;
    logic [NB-1:0] recv_msg;
    logic          send_val;
    logic          send_rdy;
    logic [NB-1:0] send_msg;
    logic          overflow;
    logic          frame_err;
    logic [0:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int ferr_cnt = 0;
    int rdy_cnt = 0;

    logic [NB-1:0] exp_q[$];

    spi_minion #(.nbits(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .recv_msg  (recv_msg),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_msg  (send_msg),
        .overflow  (overflow),
        .frame_err (frame_err),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one pop per accepted packet, plus pulse counters.
    always @(negedge clk) begin
        if (reset && recv_val && recv_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_packet: actual=%h expected=none", recv_msg);
            end else begin
                check("recv_msg", 64'(recv_msg), 64'(exp_q.pop_front()));
            end
        end
        if (overflow)  ovf_cnt++;
        if (frame_err) ferr_cnt++;
        if (send_rdy)  rdy_cnt++;
    end

    // Mode-0 master at clk/8: mosi set while sclk low, miso sampled on sclk rise.
    task automatic master_bits(input logic [63:0] word, input int n, output logic [63:0] cap);
        cap = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = word[i];
            #40 sclk = 1'b1;
            cap = {cap[62:0], miso};
            #40 sclk = 1'b0;
        end
    endtask

    task automatic master_frame(input logic [63:0] word, input int n, output logic [63:0] cap);
        cs = 1'b0;
        #80;
        master_bits(word, n, cap);
        #40 cs = 1'b1;
        mosi = 1'b0;
        #200;
    endtask

    logic [63:0] cap;
    int ovf0, ferr0, rdy0;

    initial begin
        reset    = 1'b0;
        cs       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        recv_rdy = 1'b1;
        send_val = 1'b0;
        send_msg = '0;

        repeat (3) @(negedge clk);
        check("rst_recv_val",  64'(recv_val),  64'd0);
        check("rst_recv_msg",  64'(recv_msg),  64'd0);
        check("rst_send_rdy",  64'(send_rdy),  64'd0);
        check("rst_miso",      64'(miso),      64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_state",     64'(dbg_state), 64'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Basic transfer with a loaded transmit word.
        send_val = 1'b1;
        send_msg = 34'h2_0000_0001;
        rdy0 = rdy_cnt;
        exp_q.push_back(34'h1_2345_6789);
        master_frame(64'(34'h1_2345_6789), NB, cap);
        check("miso_word", cap, 64'(34'h2_0000_0001));
        check("send_rdy_pulses", 64'(rdy_cnt - rdy0), 64'd1);
        check("idle_miso", 64'(miso), 64'd0);

        // No send_val: transmit register is zero, send_msg ignored.
        send_val = 1'b0;
        send_msg = 34'h3_FFFF_FFFF;
        rdy0 = rdy_cnt;
        exp_q.push_back(34'h0_DEAD_BEEF);
        master_frame(64'(34'h0_DEAD_BEEF), NB, cap);
        check("miso_zero", cap, 64'd0);
        check("send_rdy_once", 64'(rdy_cnt - rdy0), 64'd1);

        // Two frames with no downstream ready: second packet dropped.
        recv_rdy = 1'b0;
        ovf0 = ovf_cnt;
        exp_q.push_back(34'h2_AAAA_5555);
        master_frame(64'(34'h2_AAAA_5555), NB, cap);
        check("ovf_after_first", 64'(ovf_cnt - ovf0), 64'd0);
        master_frame(64'(34'h1_5555_AAAA), NB, cap);
        check("ovf_after_second", 64'(ovf_cnt - ovf0), 64'd1);
        check("held_val", 64'(recv_val), 64'd1);
        check("held_msg", 64'(recv_msg), 64'(34'h2_AAAA_5555));
        recv_rdy = 1'b1;
        repeat (4) @(negedge clk);
        check("drained_val", 64'(recv_val), 64'd0);

        // Short frame of 20 bits, then a good frame.
        ferr0 = ferr_cnt;
        master_frame(64'(20'hA5A5A), 20, cap);
        check("short_frame_err", 64'(ferr_cnt - ferr0), 64'd1);
        check("short_no_val", 64'(recv_val), 64'd0);
        exp_q.push_back(34'h0_1357_9BDF);
        master_frame(64'(34'h0_1357_9BDF), NB, cap);
        check("after_short_err", 64'(ferr_cnt - ferr0), 64'd1);

        // Reset mid-frame after 10 bits.
        ferr0 = ferr_cnt;
        ovf0 = ovf_cnt;
        cs = 1'b0;
        #80;
        master_bits(64'(10'h3C5), 10, cap);
        reset = 1'b0;
        cs    = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_state", 64'(dbg_state), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_val", 64'(recv_val), 64'd0);
        check("midrst_state_idle", 64'(dbg_state), 64'd0);
        exp_q.push_back(34'h3_0F0F_F0F0);
        master_frame(64'(34'h3_0F0F_F0F0), NB, cap);
        check("midrst_no_pulses", 64'((ferr_cnt - ferr0) + (ovf_cnt - ovf0)), 64'd0);

        // 40 sclk cycles: only the first 34 bits count, no frame error.
        ferr0 = ferr_cnt;
        exp_q.push_back(34'h2_4680_ACE1);
        master_frame({24'd0, 34'h2_4680_ACE1, 6'b101101}, 40, cap);
        check("long_no_frame_err", 64'(ferr_cnt - ferr0), 64'd0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("total_frame_err", 64'(ferr_cnt), 64'd1);
        check("total_overflow", 64'(ovf_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_minion.md
SPI_MINION -- requirements
Module: spi_minion

Interface
REQ-001 Parameter nbits, default 34, the fixed packet width in bits per chip-select frame.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cs  input  1  SPI chip select from master, active-low, asynchronous to clk.
REQ-005 sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-006 mosi  input  1  serial data from master, MSB first.
REQ-007 miso  output  1  serial data to master, MSB first.
REQ-008 recv_val  output  1  received packet valid.
REQ-009 recv_rdy  input  1  downstream ready to accept the received packet.
REQ-010 recv_msg  output  nbits  received packet.
REQ-011 send_val  input  1  upstream packet available for transmission.
REQ-012 send_rdy  output  1  block accepts send_msg this cycle.
REQ-013 send_msg  input  nbits  packet to transmit on miso.
REQ-014 overflow  output  1  one-cycle pulse when a completed packet is dropped.
REQ-015 frame_err  output  1  one-cycle pulse when cs deasserts with a bit count other than nbits.

Function
REQ-016 cs, sclk and mosi shall each pass through a two-flop synchronizer; a third sclk flop and a third cs flop shall provide edge detection; mosi shall be sampled from its second synchronizer stage.
REQ-017 sclk_pos shall be high for one clk when synchronized sclk goes 0->1; sclk_neg shall be high for one clk on 1->0; cs_fall and cs_rise are defined the same way on synchronized cs.
REQ-018 The FSM shall have the states IDLE and ACTIVE.
REQ-019 IDLE->ACTIVE on cs_fall: bit counter cleared, receive shift register cleared.
REQ-020 ACTIVE->IDLE on cs_rise.
REQ-021 In ACTIVE, each sclk_pos shall shift mosi into the receive shift register LSB, shifting left, and shall increment the bit counter, which saturates at nbits.
REQ-022 sclk_pos or sclk_neg while in IDLE shall be ignored.
REQ-023 The bit counter width shall be $clog2(nbits+1).
REQ-024 When the counter reaches nbits, the receive register value shall be offered as a completed packet exactly once per frame.
REQ-025 Further sclk_pos in the same frame after the count reaches nbits shall not alter the receive register or re-offer the packet.
REQ-026 A completed packet shall be written to the recv_msg holding register and recv_val set the next cycle, if recv_val is low or recv_rdy is high in that cycle.
REQ-027 If recv_val is high and recv_rdy is low when a packet completes, the new packet shall be dropped, recv_msg shall be left unchanged, and overflow shall pulse.
REQ-028 recv_val shall clear on a cycle with recv_val and recv_rdy both high, unless a new packet is written in that same cycle.
REQ-029 On cs_rise with counter not equal to nbits, frame_err shall pulse and no packet shall be offered.
REQ-030 send_rdy shall equal (state==IDLE) and cs_fall; the transmit register loads send_msg on that cycle if send_val is high, otherwise it loads all zeros.
REQ-031 send_rdy shall not depend combinationally on send_val.
REQ-032 miso shall be the transmit register MSB.
REQ-033 In ACTIVE, each sclk_neg shall shift the transmit register left, filling with 0.
REQ-034 In IDLE, miso shall be 0.
REQ-035 cs_fall and cs_rise in the same cycle cannot occur, because each is a single synchronized signal.
REQ-036 A cs glitch shorter than two clk cycles need not be detected.

Reset
REQ-037 While reset is low, the following shall hold:
- state = IDLE
- counters and all shift registers = 0
- recv_msg = 0
- recv_val = 0
- send_rdy = 0
- miso = 0
- overflow = 0
- frame_err = 0
- synchronizer flops: cs flops = 1, sclk flops = 0
REQ-038 Reset asserted mid-frame shall abort the frame; after release, the block shall wait in IDLE for the next cs_fall, with no packet offered and no pulses.

Verification
REQ-039 Case nbits=34, send_val=1, send_msg=34'h2_0000_0001, master sends 34'h1_2345_6789 in mode 0 with sclk at clk/8 -> recv_val=1 and recv_msg=34'h1_2345_6789; master captures 34'h2_0000_0001 on miso.
REQ-040 Case send_val=0 at cs_fall -> send_rdy pulses once, no load of send_msg, miso stays 0 for all 34 bits.
REQ-041 Case two full frames with recv_rdy=0 throughout -> first packet held in recv_msg; overflow pulses exactly once after the second frame completes.
REQ-042 Case cs deasserted after 20 sclk edges -> frame_err pulses once, recv_val remains 0, next full frame is received correctly.
REQ-043 Case reset pulled low after 10 bits, then released, then a full frame -> no packet from the aborted frame; the full frame is delivered intact.
REQ-044 Case 40 sclk cycles in one frame -> exactly one packet equal to the first 34 mosi bits and no frame_err.
